// File: rtl/uart_transmitter_if.sv
// uart_transmitter_if
// Byte-wide ready/valid handshake between the MMIO write side and the UART
// transmitter.
//   data_in        byte offered by the source
//   data_in_valid  source has a byte this cycle
//   data_in_ready  transmitter can take a byte this cycle
// The master modport is the byte source and the slave modport is the transmitter.
interface uart_transmitter_if;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;

  modport master (
    output data_in,
    output data_in_valid,
    input  data_in_ready
  );

  modport slave (
    input  data_in,
    input  data_in_valid,
    output data_in_ready
  );
endinterface

// File: rtl/uart_transmitter.sv
// uart_transmitter
// 8N1 UART transmitter. It takes one byte per ready/valid handshake and
// serializes it as a frame: one start bit, eight data bits LSB first, and one
// stop bit. Each bit lasts CLOCK_FREQ/BAUD_RATE clock cycles.
// Ports:
//   clk         core clock; all state changes on its rising edge
//   rst_n       asynchronous active-low reset
//   tx_if       slave side of the byte handshake (data_in, data_in_valid,
//               data_in_ready)
//   serial_out  registered UART line; idles high
module uart_transmitter #(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_transmitter_if.slave   tx_if,
  output logic                serial_out
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W = (SYMBOL_EDGE_TIME > 1) ? $clog2(SYMBOL_EDGE_TIME) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(SYMBOL_EDGE_TIME - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] baud_next;
  logic [2:0]       bit_cnt;
  logic [2:0]       bit_next;
  logic [7:0]       shift_reg;
  logic [7:0]       shift_next;
  logic             serial_next;
  logic             symbol_done;

  // The last cycle of each bit period; every state transition other than the
  // handshake happens here.
  assign symbol_done = (baud_cnt == BAUD_LAST);

  // Ready depends only on the state. The asynchronous reset forces IDLE, so
  // ready rises as soon as rst_n goes low.
  assign tx_if.data_in_ready = (state == IDLE);

  // State register. serial_out is registered as well, so the line has no
  // combinational path from the handshake inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      serial_out <= 1'b1;
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_cnt    <= bit_next;
      shift_reg  <= shift_next;
      serial_out <= serial_next;
    end
  end

  // Next-state logic. serial_next is the line level for the cycle after this
  // edge. Each transition therefore loads the level of the state being
  // entered, which keeps every symbol exactly SYMBOL_EDGE_TIME cycles long
  // after the accepting edge. The shift register loads only in IDLE, so later
  // changes on data_in cannot disturb a frame in progress.
  always_comb begin
    state_next  = state;
    baud_next   = '0;
    bit_next    = bit_cnt;
    shift_next  = shift_reg;
    serial_next = serial_out;

    if (state != IDLE) begin
      baud_next = symbol_done ? '0 : baud_cnt + 1'b1;
    end

    case (state)
      IDLE: begin
        serial_next = 1'b1;
        if (tx_if.data_in_valid) begin
          shift_next  = tx_if.data_in;
          baud_next   = '0;
          bit_next    = '0;
          state_next  = START;
          serial_next = 1'b0;
        end
      end
      START: begin
        if (symbol_done) begin
          state_next  = DATA;
          serial_next = shift_reg[0];
        end
      end
      DATA: begin
        if (symbol_done) begin
          shift_next = shift_reg >> 1;
          bit_next   = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state_next  = STOP;
            serial_next = 1'b1;
          end else begin
            serial_next = shift_reg[1];
          end
        end
      end
      STOP: begin
        serial_next = 1'b1;
        if (symbol_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next  = IDLE;
        serial_next = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter
// Self-checking bench for uart_transmitter at S = 10 cycles per bit.
// A waveform-queue reference predicts serial_out and data_in_ready on every
// cycle. A separate mid-bit sampling receiver decodes frames and matches them
// against the accepted bytes.
module tb_uart_transmitter;

  localparam int S = 10;

  logic clk;
  logic rst_n;
  logic serial_out;

  uart_transmitter_if tx_if ();

  uart_transmitter #(
    .CLOCK_FREQ(1000),
    .BAUD_RATE (100)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_if     (tx_if),
    .serial_out(serial_out)
  );

  int         vectors;
  int         miscompares;
  int         accepts;
  int         cyc;
  bit         line_q[$];
  logic [7:0] sent_q[$];
  int         accept_time[$];

  // Core clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Every comparison goes through this task, which counts it and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual,
               expected, cyc);
    end
  endtask

  // Reference model. An accepted byte appends its complete 10*S-cycle line
  // waveform to a queue, and one entry is consumed per clock. The transmitter
  // is ready exactly when no waveform is pending. Reset discards everything.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q.delete();
      sent_q.delete();
    end else begin
      cyc++;
      if (line_q.size() != 0) begin
        void'(line_q.pop_front());
      end else if (tx_if.data_in_valid === 1'b1) begin
        for (int i = 0; i < S; i++) line_q.push_back(1'b0);
        for (int k = 0; k < 8; k++)
          for (int i = 0; i < S; i++) line_q.push_back(tx_if.data_in[k]);
        for (int i = 0; i < S; i++) line_q.push_back(1'b1);
        sent_q.push_back(tx_if.data_in);
        accept_time.push_back(cyc);
        accepts++;
      end
    end
  end

  // Compare both outputs against the prediction in the middle of every cycle.
  always @(negedge clk) begin
    checkOutput("serial_out", serial_out,
                (line_q.size() != 0) ? line_q[0] : 1'b1);
    checkOutput("data_in_ready", tx_if.data_in_ready, line_q.size() == 0);
  end

  // Receiver model. It detects a falling edge, samples each bit at its middle,
  // checks the start and stop levels, and matches the decoded byte against the
  // oldest accepted byte. A frame that sees reset is discarded.
  initial begin : rx_model
    logic [7:0] rx_byte;
    bit         aborted;
    rx_byte = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && serial_out === 1'b0) begin
        aborted = 1'b0;
        repeat (S / 2 - 1) begin
          @(negedge clk);
          if (rst_n !== 1'b1) aborted = 1'b1;
        end
        if (!aborted) checkOutput("rx_start", serial_out, 0);
        for (int k = 0; k < 8; k++) begin
          repeat (S) begin
            @(negedge clk);
            if (rst_n !== 1'b1) aborted = 1'b1;
          end
          rx_byte[k] = serial_out;
        end
        repeat (S) begin
          @(negedge clk);
          if (rst_n !== 1'b1) aborted = 1'b1;
        end
        if (!aborted) begin
          checkOutput("rx_stop", serial_out, 1);
          if (sent_q.size() == 0) checkOutput("rx_extra_frame", 1, 0);
          else checkOutput("rx_byte", rx_byte, sent_q.pop_front());
        end
      end
    end
  end

  // Offer one byte and wait, with a bound, until the model accepts it. With
  // keep_valid set, valid stays high so the next call forms a back-to-back pair.
  task automatic applyStimulus(input logic [7:0] b, input bit keep_valid);
    int start_acc;
    bit got;
    @(negedge clk);
    tx_if.data_in       = b;
    tx_if.data_in_valid = 1'b1;
    start_acc = accepts;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (accepts != start_acc) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("accept_timeout", got, 1);
    if (!keep_valid) begin
      @(negedge clk);
      tx_if.data_in_valid = 1'b0;
    end
  endtask

  // Wait, with a bound, until the predicted line is idle again.
  task automatic waitIdle();
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (line_q.size() == 0) break;
    end
    repeat (5) @(negedge clk);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: run did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int         gap;
    logic [7:0] b;
    vectors = 0;
    miscompares = 0;
    accepts = 0;
    cyc = 0;
    rst_n = 1'b1;
    tx_if.data_in = 8'h00;
    tx_if.data_in_valid = 1'b0;

    $display("[TB] reset and idle line");
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);

    $display("[TB] single byte 0x55");
    applyStimulus(8'h55, 1'b0);
    waitIdle();

    $display("[TB] back-to-back 0xA3, 0xFF");
    applyStimulus(8'hA3, 1'b1);
    applyStimulus(8'hFF, 1'b0);
    waitIdle();
    checkOutput("b2b_gap", accept_time[accept_time.size()-1] -
                accept_time[accept_time.size()-2], 101);

    $display("[TB] busy ignore and data stability");
    applyStimulus(8'h0F, 1'b0);
    repeat (34) @(negedge clk);
    tx_if.data_in = 8'hF0;
    tx_if.data_in_valid = 1'b1;
    @(negedge clk);
    tx_if.data_in_valid = 1'b0;
    repeat (20) begin
      tx_if.data_in = ~tx_if.data_in;
      @(negedge clk);
    end
    waitIdle();
    checkOutput("busy_accepts", accepts, 4);

    $display("[TB] reset mid-frame");
    applyStimulus(8'h00, 1'b0);
    repeat (46) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_serial", serial_out, 1);
    checkOutput("rst_ready", tx_if.data_in_ready, 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    applyStimulus(8'h81, 1'b0);
    waitIdle();

    $display("[TB] random regression");
    for (int i = 0; i < 200; i++) begin
      b = 8'($urandom_range(0, 255));
      gap = $urandom_range(0, 12);
      applyStimulus(b, (gap == 0) && (i != 199));
      if (gap != 0) repeat (gap) @(negedge clk);
    end
    waitIdle();
    repeat (20) @(negedge clk);
    checkOutput("rx_pending", sent_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

8N1 UART transmitter serving the core's memory-mapped UART TX path. It accepts one byte per ready/valid handshake from the MMIO write side and serializes it onto `serial_out`. The frame is one start bit, eight data bits LSB first, and one stop bit. `data_in_ready` feeds the MMIO TX-ready status bit, so software polls it before writing the TX data register.

## Interface

Parameters:
- `CLOCK_FREQ`, default 125_000_000, core clock frequency in Hz.
- `BAUD_RATE`, default 115_200, line rate in bits/s.
- Derived, not overridable: `SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE` (integer divide, 1085 at defaults). Counter width is `$clog2(SYMBOL_EDGE_TIME)`.

Ports:
- `clk`  in  1  core clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_in`  in  8  byte to transmit; sampled only on the accepting edge.
- `data_in_valid`  in  1  source has a byte.
- `data_in_ready`  out  1  transmitter can accept a byte this cycle.
- `serial_out`  out  1  UART line; idles high.

## Operation

States: IDLE, START, DATA, STOP.
- **Handshake.** A transfer occurs on a rising edge where `data_in_valid && data_in_ready`.
  - `data_in_ready` is combinational: high iff state == IDLE.
  - `data_in_valid` outside IDLE is ignored. The byte is not lost; the source holds it until ready.
- **IDLE**
  - `serial_out` = 1.
  - On a transfer: latch `data_in` into the shift register, clear the baud and bit counters, go to START.
- **START**
  - `serial_out` = 0 for SYMBOL_EDGE_TIME cycles, then go to DATA.
- **DATA**
  - `serial_out` = shift register bit 0.
  - Every SYMBOL_EDGE_TIME cycles, shift right by one and increment the bit counter.
  - After the 8th bit period, go to STOP.
- **STOP**
  - `serial_out` = 1 for SYMBOL_EDGE_TIME cycles, then go to IDLE.
- **Baud counter**
  - Counts 0 .. SYMBOL_EDGE_TIME-1 and wraps to 0 at each symbol boundary.
  - Held at 0 in IDLE.
- **Bit counter**
  - 3 bits, counts 0..7 in DATA.
  - Its transition from 7 together with the baud wrap exits DATA; no overflow is used.
- **Data stability.** Changes on `data_in` after the accepting edge have no effect on the frame in progress.
- **Reset** (asynchronous, any time, including mid-frame):
  - state = IDLE, `serial_out` = 1, counters and shift register = 0.
  - `data_in_ready` = 1 as soon as `rst_n` is low.
  - A partial frame is aborted, not resumed.
  - Release of `rst_n` takes effect at the next rising edge.

## Timing

- `serial_out` is a register output; it has no combinational path from `data_in` or `data_in_valid`.
- Let E0 be the accepting edge. After E0:
  - cycles 1..S: `serial_out` = 0 (start bit), where S = SYMBOL_EDGE_TIME.
  - cycles S·(k+1)+1 .. S·(k+2): `serial_out` = data bit k, for k = 0..7.
  - cycles 9S+1 .. 10S: `serial_out` = 1 (stop bit).
- At edge E0+10S the state returns to IDLE and `data_in_ready` rises.
- Earliest next accepting edge is E0+10S+1. The line stays high in between, so the stop bit effectively lasts S+1 cycles under back-to-back traffic.
- `data_in_ready` is low for exactly 10S cycles per frame.
- Frame-to-frame period is at least 10S+1 cycles.
- Valid asserted for exactly one cycle while ready is high is sufficient for a transfer.

## Test plan

Use CLOCK_FREQ=1000, BAUD_RATE=100 (S=10).

1. **Reset values.** Hold `rst_n`=0 for 3 cycles, then release. Expect `serial_out`=1 and `data_in_ready`=1 throughout and after; no activity with `data_in_valid`=0 for 200 cycles.
2. **Single byte.** Send 0x55 with a one-cycle valid pulse.
   - Expect `serial_out` pattern 0,1,0,1,0,1,0,1,0,1, each level lasting exactly 10 cycles starting the cycle after acceptance.
   - Expect ready low for 100 cycles, then high.
3. **Back-to-back.** Send 0xA3 then 0xFF with valid held high.
   - Expect second acceptance exactly 101 cycles after the first.
   - Expect a decoded LSB-first bitstream of 0xA3 then 0xFF, and line high between frames.
4. **Busy ignore and data stability.**
   - During frame 0x0F, pulse valid with `data_in`=0xF0 at cycle 35 and toggle `data_in` every cycle.
   - Expect frame bits to still decode to 0x0F, no second frame, and ready to stay low until cycle 100.
5. **Reset mid-frame.**
   - Assert `rst_n`=0 at cycle 47 of frame 0x00. Expect `serial_out`=1 and ready=1 immediately, without waiting for an edge.
   - After release, send 0x81. Expect a clean full frame for 0x81.
6. **Random regression.** Send 200 random bytes with random valid gaps into a bench UART receiver model. Expect every byte received in order with no framing errors.
